// File: rtl/di_term_arbiter.sv
// di_term_arbiter
//
// Routes the HostInterface device-interface bus to up to four terminal
// slots and returns the selected slot's read data and ready handshakes.
// A watchdog forces completion of a transfer whose terminal never becomes
// ready, and each forced completion is logged in sticky status registers.
//
// Handshake: a transfer is open while di_read_mode / di_write_mode is high.
// A word moves on every cycle in which the mode is high and the matching
// di_*_rdy is high. di_*_rdy is combinational from the selected terminal,
// or tied high when the address is unmapped or the transfer is forced.
//
// Ports:
//   ifclk, reset         clock (rising edge), asynchronous active-high reset
//   di_term_addr         terminal address from HostInterface
//   di_read_mode/_write_mode   transfer in progress
//   di_read_req/di_read/di_write  per-word strobes (clear the watchdog)
//   di_reg_datao         registered read data to HostInterface
//   di_read_rdy/_write_rdy     ready to HostInterface
//   term_reg_datao       slot i read data at [16i+15:16i]
//   term_read_rdy/_write_rdy   per-slot ready
//   term_sel             one-hot effective slot, zero when unmapped
//   err_clear            clears timeout status
//   timeout_err          sticky timeout flag
//   timeout_slot         slot of the most recent timeout
//   err_count            saturating timeout event count
//   dbg_state            FSM state (0 IDLE, 1 READ, 2 WRITE, 3 FORCE)
module di_term_arbiter #(
  parameter int          NUM_TERMS = 4,
  parameter logic [15:0] TERM_BASE = 16'h0000,
  parameter int          TIMEOUT   = 255,
  parameter logic [15:0] FILL_DATA = 16'hDEAD
) (
  input  logic                   ifclk,
  input  logic                   reset,
  input  logic [15:0]            di_term_addr,
  input  logic                   di_read_mode,
  input  logic                   di_write_mode,
  input  logic                   di_read_req,
  input  logic                   di_read,
  input  logic                   di_write,
  output logic [15:0]            di_reg_datao,
  output logic                   di_read_rdy,
  output logic                   di_write_rdy,
  input  logic [16*NUM_TERMS-1:0] term_reg_datao,
  input  logic [NUM_TERMS-1:0]   term_read_rdy,
  input  logic [NUM_TERMS-1:0]   term_write_rdy,
  output logic [NUM_TERMS-1:0]   term_sel,
  input  logic                   err_clear,
  output logic                   timeout_err,
  output logic [1:0]             timeout_slot,
  output logic [7:0]             err_count,
  output logic [1:0]             dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_FORCE = 2'd3
  } state_t;

  localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);
  localparam logic [15:0] NUM_W     = 16'(NUM_TERMS);

  state_t      state, state_nxt;
  logic [15:0] wd_cnt, wd_nxt;
  logic [1:0]  lat_slot;
  logic        lat_hit;

  logic [15:0] addr_off;
  logic        live_hit;
  logic [1:0]  live_slot;
  logic        eff_hit;
  logic [1:0]  eff_slot;
  logic [3:0]  rd_pad, wr_pad, sel_pad;
  logic [63:0] data_pad;
  logic [15:0] sel_rdata;
  logic        sink;
  logic        strobe;
  logic        timeout_evt;

  // Decode wraps in 16 bits, so addresses below TERM_BASE are unmapped.
  assign addr_off  = di_term_addr - TERM_BASE;
  assign live_hit  = (addr_off < NUM_W);
  assign live_slot = addr_off[1:0];

  // Outside IDLE the slot is frozen so address changes mid-transfer are ignored.
  assign eff_hit  = (state == S_IDLE) ? live_hit  : lat_hit;
  assign eff_slot = (state == S_IDLE) ? live_slot : lat_slot;

  // Pad the per-slot buses to four slots so indexing is uniform.
  always_comb begin
    rd_pad   = '0;
    wr_pad   = '0;
    data_pad = '0;
    for (int i = 0; i < NUM_TERMS; i++) begin
      rd_pad[i]            = term_read_rdy[i];
      wr_pad[i]            = term_write_rdy[i];
      data_pad[16*i +: 16] = term_reg_datao[16*i +: 16];
    end
  end

  assign sel_rdata = data_pad[{eff_slot, 4'b0000} +: 16];
  assign sel_pad   = eff_hit ? (4'b0001 << eff_slot) : 4'b0000;
  assign term_sel  = sel_pad[NUM_TERMS-1:0];

  // Unmapped slots and forced transfers sink every word.
  assign sink         = (state == S_FORCE) || !eff_hit;
  assign di_read_rdy  = sink | rd_pad[eff_slot];
  assign di_write_rdy = sink | wr_pad[eff_slot];

  assign strobe    = di_read_req | di_read | di_write;
  assign dbg_state = state;

  // Next state. Mode deassertion wins over a timeout, and a ready seen in
  // the expiry cycle prevents the force.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (di_read_mode)       state_nxt = S_READ;
        else if (di_write_mode) state_nxt = S_WRITE;
      end
      S_READ: begin
        if (!di_read_mode)                            state_nxt = S_IDLE;
        else if (!di_read_rdy && wd_cnt >= TIMEOUT_W) state_nxt = S_FORCE;
      end
      S_WRITE: begin
        if (!di_write_mode)                            state_nxt = S_IDLE;
        else if (!di_write_rdy && wd_cnt >= TIMEOUT_W) state_nxt = S_FORCE;
      end
      S_FORCE: begin
        if (!di_read_mode && !di_write_mode) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign timeout_evt = (state_nxt == S_FORCE) && (state != S_FORCE);

  // Watchdog counts consecutive not-ready cycles of the open transfer and
  // parks at TIMEOUT rather than wrapping.
  always_comb begin
    wd_nxt = wd_cnt;
    if (strobe) begin
      wd_nxt = '0;
    end else begin
      case (state)
        S_READ: begin
          if (di_read_rdy)             wd_nxt = '0;
          else if (wd_cnt < TIMEOUT_W) wd_nxt = wd_cnt + 16'd1;
        end
        S_WRITE: begin
          if (di_write_rdy)            wd_nxt = '0;
          else if (wd_cnt < TIMEOUT_W) wd_nxt = wd_cnt + 16'd1;
        end
        default: wd_nxt = '0;
      endcase
    end
  end

  always_ff @(posedge ifclk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      wd_cnt       <= '0;
      lat_slot     <= '0;
      lat_hit      <= 1'b0;
      di_reg_datao <= '0;
      timeout_err  <= 1'b0;
      timeout_slot <= '0;
      err_count    <= '0;
    end else begin
      state  <= state_nxt;
      wd_cnt <= wd_nxt;

      if (state == S_IDLE && state_nxt != S_IDLE) begin
        lat_slot <= live_slot;
        lat_hit  <= live_hit;
      end

      if (state == S_FORCE || state_nxt == S_FORCE || !eff_hit)
        di_reg_datao <= FILL_DATA;
      else
        di_reg_datao <= sel_rdata;

      // A timeout in the same cycle as err_clear is logged as the first event.
      if (timeout_evt) begin
        timeout_err  <= 1'b1;
        timeout_slot <= lat_slot;
        if (err_clear)              err_count <= 8'd1;
        else if (err_count != 8'hFF) err_count <= err_count + 8'd1;
      end else if (err_clear) begin
        timeout_err  <= 1'b0;
        timeout_slot <= '0;
        err_count    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_di_term_arbiter.sv
// Directed testbench for di_term_arbiter. Instance dut uses TIMEOUT=8,
// instance dut_slow uses TIMEOUT=255; both share all inputs.
module tb_di_term_arbiter;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_FORCE = 2'd3;

  logic        ifclk = 1'b0;
  logic        reset;
  logic [15:0] di_term_addr;
  logic        di_read_mode, di_write_mode, di_read_req, di_read, di_write;
  logic [63:0] term_reg_datao;
  logic [3:0]  term_read_rdy, term_write_rdy;
  logic        err_clear;

  logic [15:0] di_reg_datao;
  logic        di_read_rdy, di_write_rdy, timeout_err;
  logic [3:0]  term_sel;
  logic [1:0]  timeout_slot, dbg_state;
  logic [7:0]  err_count;

  logic [15:0] s_di_reg_datao;
  logic        s_di_read_rdy, s_di_write_rdy, s_timeout_err;
  logic [3:0]  s_term_sel;
  logic [1:0]  s_timeout_slot, s_dbg_state;
  logic [7:0]  s_err_count;

  int checks = 0;
  int errors = 0;

  // Clock / reset
  always #5 ifclk = ~ifclk;

  di_term_arbiter #(.NUM_TERMS(4), .TERM_BASE(16'h0000), .TIMEOUT(8), .FILL_DATA(16'hDEAD)) dut (
    .ifclk(ifclk), .reset(reset), .di_term_addr(di_term_addr),
    .di_read_mode(di_read_mode), .di_write_mode(di_write_mode),
    .di_read_req(di_read_req), .di_read(di_read), .di_write(di_write),
    .di_reg_datao(di_reg_datao), .di_read_rdy(di_read_rdy), .di_write_rdy(di_write_rdy),
    .term_reg_datao(term_reg_datao), .term_read_rdy(term_read_rdy), .term_write_rdy(term_write_rdy),
    .term_sel(term_sel), .err_clear(err_clear), .timeout_err(timeout_err),
    .timeout_slot(timeout_slot), .err_count(err_count), .dbg_state(dbg_state)
  );

  di_term_arbiter #(.NUM_TERMS(4), .TERM_BASE(16'h0000), .TIMEOUT(255), .FILL_DATA(16'hDEAD)) dut_slow (
    .ifclk(ifclk), .reset(reset), .di_term_addr(di_term_addr),
    .di_read_mode(di_read_mode), .di_write_mode(di_write_mode),
    .di_read_req(di_read_req), .di_read(di_read), .di_write(di_write),
    .di_reg_datao(s_di_reg_datao), .di_read_rdy(s_di_read_rdy), .di_write_rdy(s_di_write_rdy),
    .term_reg_datao(term_reg_datao), .term_read_rdy(term_read_rdy), .term_write_rdy(term_write_rdy),
    .term_sel(s_term_sel), .err_clear(err_clear), .timeout_err(s_timeout_err),
    .timeout_slot(s_timeout_slot), .err_count(s_err_count), .dbg_state(s_dbg_state)
  );

  // Driver: advance n cycles, returning at the falling edge.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge ifclk);
      @(negedge ifclk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; di_term_addr = 16'h0000; di_read_mode = 0; di_write_mode = 0;
    di_read_req = 0; di_read = 0; di_write = 0; term_reg_datao = '0;
    term_read_rdy = 4'b0001; term_write_rdy = 4'b0000; err_clear = 0;
    #2;
    checks++; if (di_reg_datao !== 16'h0000) begin errors++; $display("FAIL rst_data: got %h exp 0000", di_reg_datao); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b exp 0", timeout_err); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL rst_count: got %0d exp 0", err_count); end
    checks++; if (timeout_slot !== 2'd0) begin errors++; $display("FAIL rst_slot: got %0d exp 0", timeout_slot); end
    checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL rst_state: got %0d exp 0", dbg_state); end
    checks++; if (term_sel !== 4'b0001) begin errors++; $display("FAIL rst_sel: got %b exp 0001", term_sel); end
    checks++; if (di_read_rdy !== 1'b1 || di_write_rdy !== 1'b0) begin errors++; $display("FAIL rst_rdy: got %b%b exp 10", di_read_rdy, di_write_rdy); end
    di_term_addr = 16'h0007;
    #1;
    checks++; if (term_sel !== 4'b0000) begin errors++; $display("FAIL rst_unmapped_sel: got %b exp 0000", term_sel); end
    checks++; if (di_read_rdy !== 1'b1 || di_write_rdy !== 1'b1) begin errors++; $display("FAIL rst_unmapped_rdy: got %b%b exp 11", di_read_rdy, di_write_rdy); end
    cyc(2);
    reset = 1'b0;
    di_term_addr = 16'h0000;
  endtask

  task automatic test_mapped_read();
    term_read_rdy = 4'b1111;
    term_reg_datao = {48'h0, 16'h1234};
    di_read_mode = 1'b1;
    #1;
    checks++; if (di_reg_datao !== 16'h0000) begin errors++; $display("FAIL map_latency: got %h exp 0000", di_reg_datao); end
    for (int w = 0; w < 4; w++) begin
      di_read_req = 1'b1;
      cyc(1);
      #1;
      checks++; if (di_read_rdy !== 1'b1) begin errors++; $display("FAIL map_rdy w%0d: got %b exp 1", w, di_read_rdy); end
      checks++; if (di_reg_datao !== 16'h1234) begin errors++; $display("FAIL map_data w%0d: got %h exp 1234", w, di_reg_datao); end
    end
    di_read_req = 1'b0;
    di_read_mode = 1'b0;
    cyc(1);
    #1;
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL map_count: got %0d exp 0", err_count); end
    checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL map_idle: got %0d exp 0", dbg_state); end
  endtask

  task automatic test_never_ready();
    cyc(1);
    di_term_addr = 16'h0001;
    term_read_rdy = 4'b0000;
    term_reg_datao = {32'h0, 16'h5555, 16'h0};
    di_read_mode = 1'b1;
    cyc(9);
    #1;
    checks++; if (dbg_state !== ST_READ || di_read_rdy !== 1'b0) begin errors++; $display("FAIL nr_before: got st%0d rdy%b exp st1 rdy0", dbg_state, di_read_rdy); end
    cyc(1);
    #1;
    checks++; if (dbg_state !== ST_FORCE) begin errors++; $display("FAIL nr_force: got %0d exp 3", dbg_state); end
    checks++; if (di_read_rdy !== 1'b1) begin errors++; $display("FAIL nr_rdy: got %b exp 1", di_read_rdy); end
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL nr_err: got %b exp 1", timeout_err); end
    checks++; if (timeout_slot !== 2'd1) begin errors++; $display("FAIL nr_slot: got %0d exp 1", timeout_slot); end
    checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL nr_count: got %0d exp 1", err_count); end
    cyc(1);
    #1;
    checks++; if (di_reg_datao !== 16'hDEAD) begin errors++; $display("FAIL nr_data: got %h exp dead", di_reg_datao); end
    di_read_mode = 1'b0;
    cyc(1);
    #1;
    checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL nr_idle: got %0d exp 0", dbg_state); end
  endtask

  task automatic test_ready_at_timeout();
    di_term_addr = 16'h0001;
    term_read_rdy = 4'b0000;
    di_read_mode = 1'b1;
    cyc(9);
    // Watchdog now sits at TIMEOUT; the terminal answers just in time.
    term_read_rdy = 4'b0010;
    #1;
    checks++; if (di_read_rdy !== 1'b1) begin errors++; $display("FAIL rat_pass: got %b exp 1", di_read_rdy); end
    cyc(1);
    #1;
    checks++; if (dbg_state !== ST_READ) begin errors++; $display("FAIL rat_noforce: got %0d exp 1", dbg_state); end
    term_read_rdy = 4'b0000;
    cyc(8);
    #1;
    checks++; if (dbg_state !== ST_READ) begin errors++; $display("FAIL rat_restart: got %0d exp 1", dbg_state); end
    cyc(1);
    #1;
    checks++; if (dbg_state !== ST_FORCE) begin errors++; $display("FAIL rat_force: got %0d exp 3", dbg_state); end
    di_read_mode = 1'b0;
    cyc(1);
  endtask

  task automatic test_addr_change();
    term_write_rdy = 4'b1111;
    di_term_addr = 16'h0002;
    di_write_mode = 1'b1;
    #1;
    checks++; if (term_sel !== 4'b0100) begin errors++; $display("FAIL ac_live: got %b exp 0100", term_sel); end
    cyc(1);
    di_term_addr = 16'h0000;
    term_write_rdy = 4'b1011;
    #1;
    checks++; if (term_sel !== 4'b0100) begin errors++; $display("FAIL ac_latched: got %b exp 0100", term_sel); end
    checks++; if (di_write_rdy !== 1'b0) begin errors++; $display("FAIL ac_rdy_slot: got %b exp 0", di_write_rdy); end
    term_write_rdy = 4'b1111;
    cyc(1);
    #1;
    checks++; if (term_sel !== 4'b0100) begin errors++; $display("FAIL ac_latched2: got %b exp 0100", term_sel); end
    di_write_mode = 1'b0;
    cyc(1);
    #1;
    checks++; if (term_sel !== 4'b0001) begin errors++; $display("FAIL ac_idle_live: got %b exp 0001", term_sel); end
    di_term_addr = 16'h0005;
    term_read_rdy = 4'b0000;
    term_write_rdy = 4'b0000;
    term_reg_datao = {4{16'h7777}};
    #1;
    checks++; if (term_sel !== 4'b0000) begin errors++; $display("FAIL um_sel: got %b exp 0000", term_sel); end
    checks++; if (di_read_rdy !== 1'b1 || di_write_rdy !== 1'b1) begin errors++; $display("FAIL um_rdy: got %b%b exp 11", di_read_rdy, di_write_rdy); end
    cyc(1);
    #1;
    checks++; if (di_reg_datao !== 16'hDEAD) begin errors++; $display("FAIL um_data: got %h exp dead", di_reg_datao); end
    di_write_mode = 1'b1;
    cyc(12);
    #1;
    checks++; if (dbg_state !== ST_WRITE || term_sel !== 4'b0000) begin errors++; $display("FAIL um_sink: got st%0d sel%b exp st2 sel0000", dbg_state, term_sel); end
    di_write_mode = 1'b0;
    cyc(1);
  endtask

  task automatic test_slow_terminal();
    logic exp_rdy;
    di_term_addr = 16'h0002;
    term_read_rdy = 4'b0000;
    di_read_mode = 1'b1;
    cyc(1);
    for (int w = 0; w < 16; w++) begin
      for (int c = 0; c < 64; c++) begin
        di_read_req = (c == 0);
        exp_rdy = (c == 63);
        term_read_rdy = {1'b0, exp_rdy, 2'b00};
        #1;
        checks++; if (s_di_read_rdy !== exp_rdy || s_dbg_state !== ST_READ) begin errors++; $display("FAIL slow w%0d c%0d: got rdy%b st%0d exp rdy%b st1", w, c, s_di_read_rdy, s_dbg_state, exp_rdy); end
        cyc(1);
      end
    end
    di_read_req = 1'b0;
    di_read_mode = 1'b0;
    cyc(1);
    #1;
    checks++; if (s_err_count !== 8'd0 || s_timeout_err !== 1'b0) begin errors++; $display("FAIL slow_status: got cnt%0d err%b exp cnt0 err0", s_err_count, s_timeout_err); end
  endtask

  task automatic test_saturation();
    err_clear = 1'b1;
    cyc(1);
    err_clear = 1'b0;
    #1;
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL sat_start: got %0d exp 0", err_count); end
    di_term_addr = 16'h0003;
    term_read_rdy = 4'b0000;
    for (int t = 0; t < 300; t++) begin
      di_read_mode = 1'b1;
      cyc(10);
      di_read_mode = 1'b0;
      cyc(1);
    end
    #1;
    checks++; if (err_count !== 8'd255) begin errors++; $display("FAIL sat_count: got %0d exp 255", err_count); end
    checks++; if (timeout_slot !== 2'd3 || timeout_err !== 1'b1) begin errors++; $display("FAIL sat_slot: got slot%0d err%b exp slot3 err1", timeout_slot, timeout_err); end
    di_read_mode = 1'b1;
    cyc(9);
    err_clear = 1'b1;
    cyc(1);
    err_clear = 1'b0;
    #1;
    checks++; if (dbg_state !== ST_FORCE) begin errors++; $display("FAIL clr_evt_state: got %0d exp 3", dbg_state); end
    checks++; if (err_count !== 8'd1 || timeout_err !== 1'b1) begin errors++; $display("FAIL clr_evt: got cnt%0d err%b exp cnt1 err1", err_count, timeout_err); end
    di_read_mode = 1'b0;
    cyc(1);
    err_clear = 1'b1;
    cyc(1);
    err_clear = 1'b0;
    #1;
    checks++; if (err_count !== 8'd0 || timeout_err !== 1'b0 || timeout_slot !== 2'd0) begin errors++; $display("FAIL clr_alone: got cnt%0d err%b slot%0d exp 0 0 0", err_count, timeout_err, timeout_slot); end
  endtask

  task automatic test_reset_mid();
    cyc(1);
    di_term_addr = 16'h0001;
    term_read_rdy = 4'b0000;
    di_read_mode = 1'b1;
    cyc(10);
    di_read_mode = 1'b0;
    cyc(1);
    di_term_addr = 16'h0002;
    term_write_rdy = 4'b0000;
    term_reg_datao = {16'h0, 16'hBEEF, 32'h0};
    di_write_mode = 1'b1;
    cyc(6);
    #1;
    checks++; if (dbg_state !== ST_WRITE || di_reg_datao !== 16'hBEEF || err_count !== 8'd1) begin errors++; $display("FAIL rm_pre: got st%0d data%h cnt%0d exp st2 databeef cnt1", dbg_state, di_reg_datao, err_count); end
    reset = 1'b1;
    #1;
    checks++; if (dbg_state !== ST_IDLE || di_reg_datao !== 16'h0000) begin errors++; $display("FAIL rm_async: got st%0d data%h exp st0 data0000", dbg_state, di_reg_datao); end
    checks++; if (timeout_err !== 1'b0 || err_count !== 8'd0 || timeout_slot !== 2'd0) begin errors++; $display("FAIL rm_status: got err%b cnt%0d slot%0d exp 0 0 0", timeout_err, err_count, timeout_slot); end
    checks++; if (term_sel !== 4'b0100 || di_write_rdy !== 1'b0) begin errors++; $display("FAIL rm_live: got sel%b wrdy%b exp sel0100 wrdy0", term_sel, di_write_rdy); end
    @(negedge ifclk);
    reset = 1'b0;
    cyc(9);
    #1;
    checks++; if (dbg_state !== ST_WRITE) begin errors++; $display("FAIL rm_count0: got %0d exp 2", dbg_state); end
    cyc(1);
    #1;
    checks++; if (dbg_state !== ST_FORCE || err_count !== 8'd1 || timeout_slot !== 2'd2) begin errors++; $display("FAIL rm_force: got st%0d cnt%0d slot%0d exp st3 cnt1 slot2", dbg_state, err_count, timeout_slot); end
    di_write_mode = 1'b0;
    cyc(1);
  endtask

  initial begin
    test_reset();
    test_mapped_read();
    test_never_ready();
    test_ready_at_timeout();
    test_addr_change();
    test_slow_terminal();
    test_saturation();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/di_term_arbiter.md
# di_term_arbiter

Routes the HostInterface device-interface (di_*) bus to up to four terminals and multiplexes their read data and ready handshakes back. The terminal is chosen by `di_term_addr`. A watchdog forces completion when a terminal never asserts ready, so the host transfer always terminates. Timeout events are logged in sticky status registers. The block sits between HostInterface and the terminal instances in the top-level FPGA wrapper.

## Interface
- `NUM_TERMS`, 4: number of terminal slots, 1..4.
- `TERM_BASE`, 16'h0000: `di_term_addr` of slot 0; slot i decodes at `TERM_BASE+i`.
- `TIMEOUT`, 255: not-ready cycles tolerated before forcing, 1..65535.
- `FILL_DATA`, 16'hDEAD: read data returned for unmapped addresses and forced completions.

Ports:
- `ifclk` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `di_term_addr` in 16: terminal address from HostInterface.
- `di_read_mode`, `di_write_mode` in 1 each: transfer in progress.
- `di_read_req`, `di_read`, `di_write` in 1 each: per-word strobes; used only to clear the watchdog.
- `di_reg_datao` out 16: read data to HostInterface.
- `di_read_rdy`, `di_write_rdy` out 1 each: ready to HostInterface.
- `term_reg_datao` in 16*NUM_TERMS: slot i read data at bits [16i+15:16i].
- `term_read_rdy`, `term_write_rdy` in NUM_TERMS each: per-slot ready.
- `term_sel` out NUM_TERMS: one-hot effective slot; all zero when unmapped.
- `err_clear` in 1: pulse that clears the error status.
- `timeout_err` out 1: sticky timeout flag.
- `timeout_slot` out 2: slot of the most recent timeout.
- `err_count` out 8: saturating count of timeout events.

## Operation
- **Decode.** `hit = (di_term_addr - TERM_BASE) < NUM_TERMS`, with the subtraction done in 16 bits. The slot number is the low 2 bits of that difference.
- **Effective select.**
  - In IDLE: the live decode.
  - In any other state: the slot latched on the cycle the state leaves IDLE.
  - An address change mid-transfer has no effect.
- **FSM states:** IDLE, READ, WRITE, FORCE.
  - IDLE→READ when `di_read_mode`. IDLE→WRITE when `di_write_mode` and not `di_read_mode`. Read has priority if both are high.
  - READ/WRITE→IDLE when the corresponding mode deasserts.
  - READ/WRITE→FORCE when the watchdog reaches `TIMEOUT`.
  - FORCE→IDLE when both modes are low.
- **Ready outputs.**
  - READ/WRITE/IDLE, mapped slot: pass through the selected `term_*_rdy` combinationally.
  - Unmapped slot: both readies are 1 (sink).
  - FORCE: both readies are 1.
- **Read data.**
  - `di_reg_datao` is registered: it equals the selected `term_reg_datao` from the previous cycle.
  - It equals `FILL_DATA` when unmapped or in FORCE.
- **Watchdog (16-bit).**
  - Cleared when: in IDLE; the selected ready is 1; or a `di_read_req`/`di_write` strobe occurs.
  - Otherwise it increments in READ (`term_read_rdy` low) or WRITE (`term_write_rdy` low).
  - It never increments past `TIMEOUT`.
- **Timeout event** (entry to FORCE):
  - `timeout_err` is set to 1.
  - `timeout_slot` takes the latched slot.
  - `err_count` increments, saturating at 255.
- **`err_clear`:** zeroes `timeout_err`, `err_count` and `timeout_slot`. If a timeout event occurs in the same cycle, the event wins: `timeout_err`=1 and `err_count`=1.

## Timing
- **Reset values:**
  - State IDLE; watchdog 0; latched slot 0.
  - `di_reg_datao`=0, `timeout_err`=0, `timeout_slot`=0, `err_count`=0.
  - Ready outputs and `term_sel` follow the live decode combinationally.
- **Reset mid-transfer:** immediate return to IDLE with all registers cleared. A pending FORCE is dropped and no event is logged.
- **Latency:** ready outputs have 0 cycles of latency; read data has 1 cycle.
- **Ready-low to forced ready:** with the selected ready low continuously from the cycle after mode entry, FORCE is entered `TIMEOUT+1` cycles after mode rises. Forced ready appears in that FORCE cycle.
- **Short transfers:** a mode pulse of a single cycle still latches the slot and returns to IDLE on the next cycle.
- **Ready in the TIMEOUT cycle:** if the selected ready rises in the same cycle the watchdog equals `TIMEOUT`, no FORCE occurs. Ready takes precedence.

## Test plan
- **Mapped read.** Slot 0 with ready held 1 and `term_reg_datao`=16'h1234; read mode for 4 words.
  - Required: `di_read_rdy`=1 throughout; `di_reg_datao`=16'h1234 one cycle after the data is presented; `err_count`=0.
- **Never-ready read.** Slot 1 with ready held 0 and `TIMEOUT`=8.
  - Required: FORCE on cycle 9 after mode rise; `di_read_rdy`=1; `di_reg_datao`=16'hDEAD; `timeout_err`=1; `timeout_slot`=1; `err_count`=1.
- **Slow terminal.** Slot 2 with ready low for 63 cycles after each `di_read_req` and `TIMEOUT`=255.
  - Required: no FORCE over 16 words; the ready passthrough tracks the terminal exactly.
- **Address change and unmapped address.** Change `di_term_addr` mid-transfer.
  - Required: `term_sel` stays on the latched slot.
  - With `di_term_addr`=`TERM_BASE+5`: `term_sel`=0, both readies 1, data `FILL_DATA`.
- **Saturation and clear.** Run 300 timeouts.
  - Required: `err_count`=255.
  - `err_clear` in the same cycle as a timeout: `err_count`=1.
  - `err_clear` alone: 0.
- **Reset mid-transfer.** Assert `reset` during WRITE with the watchdog at 5.
  - Required: all outputs at reset values asynchronously; after release the next write starts counting from 0.
